// File: rtl/mitll_merget_sched_if.sv
// Request/issue bundle between pulse sources and the MERGET issue scheduler.
interface mitll_merget_sched_if #(
    parameter int CW = 4
);
    logic          req_a;
    logic          req_b;
    logic          a;
    logic          b;
    logic [CW-1:0] pend_a;
    logic [CW-1:0] pend_b;
    logic          ovf;
    logic          idle;

    // Pulse-source / harness side
    modport master (
        output req_a, req_b,
        input  a, b, pend_a, pend_b, ovf, idle
    );

    // Scheduler side
    modport slave (
        input  req_a, req_b,
        output a, b, pend_a, pend_b, ovf, idle
    );
endinterface

// File: rtl/mitll_merget_sched.sv
// Issue scheduler for a shared two-input RSFQ merge cell: queues pulse
// requests per side and issues them as toggle edges, spaced so the merge's
// a->a, a->b, b->a and b->b timing windows are never violated.
module mitll_merget_sched #(
    parameter int CW     = 4,
    parameter int TW     = 4,
    parameter int MIN_AA = 10,
    parameter int MIN_AB = 4,
    parameter int MIN_BA = 4,
    parameter int MIN_BB = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    mitll_merget_sched_if.slave  bus
);
    typedef enum logic {
        LAST_A,
        LAST_B
    } side_t;

    localparam logic [TW-1:0] HOLD_AA = TW'(MIN_AA);
    localparam logic [TW-1:0] HOLD_AB = TW'(MIN_AB);
    localparam logic [TW-1:0] HOLD_BA = TW'(MIN_BA);
    localparam logic [TW-1:0] HOLD_BB = TW'(MIN_BB);

    side_t         last_q, last_d;
    logic          a_q, a_d;
    logic          b_q, b_d;
    logic [CW-1:0] pend_a_q, pend_a_d;
    logic [CW-1:0] pend_b_q, pend_b_d;
    logic [TW-1:0] hold_a_q, hold_a_d;
    logic [TW-1:0] hold_b_q, hold_b_d;
    logic          ovf_q, ovf_d;
    logic          idle_q, idle_d;

    logic          el_a, el_b;
    logic          issue_a, issue_b;
    logic [TW-1:0] dec_a, dec_b;

    // Arbitration, guard timers, pending counters and next-state outputs
    always_comb begin
        el_a     = (pend_a_q != '0) && (hold_a_q == '0);
        el_b     = (pend_b_q != '0) && (hold_b_q == '0);
        issue_a  = 1'b0;
        issue_b  = 1'b0;
        last_d   = last_q;
        ovf_d    = ovf_q;
        pend_a_d = pend_a_q;
        pend_b_d = pend_b_q;

        // Pointer only moves when both sides contend in the same cycle
        if (el_a && el_b) begin
            if (last_q == LAST_B) begin
                issue_a = 1'b1;
                last_d  = LAST_A;
            end else begin
                issue_b = 1'b1;
                last_d  = LAST_B;
            end
        end else if (el_a) begin
            issue_a = 1'b1;
        end else if (el_b) begin
            issue_b = 1'b1;
        end

        dec_a = (hold_a_q == '0) ? '0 : hold_a_q - TW'(1);
        dec_b = (hold_b_q == '0) ? '0 : hold_b_q - TW'(1);

        // A side becomes eligible only once its timer has counted back to 0,
        // so the cross-side floor must never shorten a longer running hold.
        hold_a_d = dec_a;
        hold_b_d = dec_b;
        if (issue_a) begin
            hold_a_d = HOLD_AA;
            hold_b_d = (dec_b > HOLD_AB) ? dec_b : HOLD_AB;
        end
        if (issue_b) begin
            hold_b_d = HOLD_BB;
            hold_a_d = (dec_a > HOLD_BA) ? dec_a : HOLD_BA;
        end

        if (bus.req_a && !issue_a) begin
            if (pend_a_q == '1)
                ovf_d = 1'b1;
            else
                pend_a_d = pend_a_q + CW'(1);
        end else if (!bus.req_a && issue_a) begin
            pend_a_d = pend_a_q - CW'(1);
        end

        if (bus.req_b && !issue_b) begin
            if (pend_b_q == '1)
                ovf_d = 1'b1;
            else
                pend_b_d = pend_b_q + CW'(1);
        end else if (!bus.req_b && issue_b) begin
            pend_b_d = pend_b_q - CW'(1);
        end

        a_d    = a_q ^ issue_a;
        b_d    = b_q ^ issue_b;
        idle_d = (pend_a_d == '0) && (pend_b_d == '0) &&
                 (hold_a_d == '0) && (hold_b_d == '0);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q   <= LAST_B;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pend_a_q <= '0;
            pend_b_q <= '0;
            hold_a_q <= '0;
            hold_b_q <= '0;
            ovf_q    <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            last_q   <= last_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pend_a_q <= pend_a_d;
            pend_b_q <= pend_b_d;
            hold_a_q <= hold_a_d;
            hold_b_q <= hold_b_d;
            ovf_q    <= ovf_d;
            idle_q   <= idle_d;
        end
    end

    assign bus.a      = a_q;
    assign bus.b      = b_q;
    assign bus.pend_a = pend_a_q;
    assign bus.pend_b = pend_b_q;
    assign bus.ovf    = ovf_q;
    assign bus.idle   = idle_q;
endmodule
